// File: rtl/ps2_arrow_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_pkg
// Brief  : Shared states, prefix bytes, arrow scancodes and held-arrow type
//          for the PS/2 arrow-key controller.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_key_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic [15:0] PS2_KEY_LEFT  = 16'hE06B;
  localparam logic [15:0] PS2_KEY_DOWN  = 16'hE072;
  localparam logic [15:0] PS2_KEY_RIGHT = 16'hE074;
  localparam logic [15:0] PS2_KEY_UP    = 16'hE075;

  typedef struct packed {
    logic left;
    logic down;
    logic right;
    logic up;
  } arrow_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_arrow_key_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ps2_arrow_key_ctrl_if
// Brief  : Byte input and completed-code / arrow-state outputs of the
//          PS/2 arrow-key controller.
// Rev    : 1.0  initial release
// ============================================================================
interface ps2_arrow_key_ctrl_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        code_valid;
  logic [15:0] scancode;
  logic        code_break;
  logic        left;
  logic        down;
  logic        right;
  logic        up;
  logic        err;

  modport master (
    output byte_valid, byte_data,
    input  code_valid, scancode, code_break, left, down, right, up, err
  );

  modport slave (
    input  byte_valid, byte_data,
    output code_valid, scancode, code_break, left, down, right, up, err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_arrow_decode.sv
`default_nettype none
// ============================================================================
// Module : ps2_arrow_decode
// Brief  : Combinational 16-bit scancode to one-hot arrow decode.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_arrow_decode
  import ps2_key_pkg::*;
(
  input  logic [15:0] code,
  output arrow_t      arrow
);

  always_comb begin
    arrow = '0;
    case (code)
      PS2_KEY_LEFT:  arrow.left  = 1'b1;
      PS2_KEY_DOWN:  arrow.down  = 1'b1;
      PS2_KEY_RIGHT: arrow.right = 1'b1;
      PS2_KEY_UP:    arrow.up    = 1'b1;
      default:       arrow = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_arrow_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ps2_arrow_key_ctrl
// Brief  : Assembles PS/2 set-2 bytes into scancodes and tracks held arrows.
//          Option macro PS2_REPEAT_FILTER_EN suppresses typematic arrow repeats.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_arrow_key_ctrl
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
)
(
  input  logic                 clk,
  input  logic                 areset,
  ps2_arrow_key_ctrl_if.slave  bus
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               done;
  logic               brk;
  logic               ext;
  logic               err_nxt;
  logic               emit;
  logic [15:0]        code_nxt;
  arrow_t             hit;
  arrow_t             held;
  arrow_t             held_nxt;

  logic               code_valid_r;
  logic [15:0]        scancode_r;
  logic               code_break_r;
  logic               err_r;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    brk       = 1'b0;
    ext       = 1'b0;
    err_nxt   = 1'b0;
    if (bus.byte_valid) begin
      cnt_nxt = '0;
      case (state)
        S_IDLE: begin
          if (bus.byte_data == PS2_PFX_EXT)      state_nxt = S_EXT;
          else if (bus.byte_data == PS2_PFX_BRK) state_nxt = S_BRK;
          else                                   done = 1'b1;
        end
        S_EXT: begin
          if (bus.byte_data == PS2_PFX_BRK) begin
            state_nxt = S_EXT_BRK;
          end else if (bus.byte_data != PS2_PFX_EXT) begin
            done      = 1'b1;
            ext       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          state_nxt = S_IDLE;
          if (is_prefix(bus.byte_data)) begin
            err_nxt = 1'b1;
          end else begin
            done = 1'b1;
            brk  = 1'b1;
          end
        end
        S_EXT_BRK: begin
          state_nxt = S_IDLE;
          if (is_prefix(bus.byte_data)) begin
            err_nxt = 1'b1;
          end else begin
            done = 1'b1;
            brk  = 1'b1;
            ext  = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      // Counter would reach TIMEOUT_CYCLES-1 on this edge: drop the partial code.
      if (cnt == CNT_LAST) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        err_nxt   = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign code_nxt = {(ext ? PS2_PFX_EXT : 8'h00), bus.byte_data};

  ps2_arrow_decode u_decode (
    .code  (code_nxt),
    .arrow (hit)
  );

  always_comb begin
    held_nxt = held;
    emit     = done;
    if (done) begin
      if (brk) held_nxt = arrow_t'(held & ~hit);
      else     held_nxt = arrow_t'(held | hit);
    end
`ifdef PS2_REPEAT_FILTER_EN
    if (done && !brk && ((held & hit) != '0)) emit = 1'b0;
`else
`endif
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      code_valid_r <= 1'b0;
      scancode_r   <= '0;
      code_break_r <= 1'b0;
      err_r        <= 1'b0;
      held         <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      code_valid_r <= emit;
      err_r        <= err_nxt;
      held         <= held_nxt;
      if (emit) begin
        scancode_r   <= code_nxt;
        code_break_r <= brk;
      end
    end
  end

  assign bus.code_valid = code_valid_r;
  assign bus.scancode   = scancode_r;
  assign bus.code_break = code_break_r;
  assign bus.err        = err_r;
  assign bus.left       = held.left;
  assign bus.down       = held.down;
  assign bus.right      = held.right;
  assign bus.up         = held.up;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ps2_arrow_key_ctrl
// Brief  : Directed self-checking bench for ps2_arrow_key_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ps2_arrow_key_ctrl;

  logic clk;
  logic areset;
  int   n_cmp;
  int   n_bad;

  ps2_arrow_key_ctrl_if bus ();

  ps2_arrow_key_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  function automatic logic [3:0] arrows();
    return {bus.left, bus.down, bus.right, bus.up};
  endfunction

  task automatic chk_code(input string tag, input logic [15:0] code, input logic brk, input logic [3:0] arr);
    chk({tag, "_valid"}, 16'(bus.code_valid), 16'h1);
    chk({tag, "_code"},  bus.scancode, code);
    chk({tag, "_break"}, 16'(bus.code_break), 16'(brk));
    chk({tag, "_arrows"}, 16'(arrows()), 16'(arr));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    areset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    tick();
    tick();
    chk("rst_valid",  16'(bus.code_valid), 16'h0);
    chk("rst_code",   bus.scancode, 16'h0000);
    chk("rst_err",    16'(bus.err), 16'h0);
    chk("rst_arrows", 16'(arrows()), 16'h0);
    areset = 1'b0;
    tick();

    // up make, then pulse must drop
    send(8'hE0); send(8'h75);
    chk_code("up_make", 16'hE075, 1'b0, 4'b0001);
    tick();
    chk("up_make_pulse_end", 16'(bus.code_valid), 16'h0);
    chk("up_make_hold_code", bus.scancode, 16'hE075);

    send(8'hE0); send(8'hF0); send(8'h75);
    chk_code("up_break", 16'hE075, 1'b1, 4'b0000);

    send(8'h1C);
    chk_code("a_make", 16'h001C, 1'b0, 4'b0000);
    send(8'hF0); send(8'h1C);
    chk_code("a_break", 16'h001C, 1'b1, 4'b0000);

    // break followed by a prefix is a protocol error
    send(8'hF0); send(8'hE0);
    chk("brk_pfx_err",   16'(bus.err), 16'h1);
    chk("brk_pfx_valid", 16'(bus.code_valid), 16'h0);
    tick();
    chk("brk_pfx_err_end", 16'(bus.err), 16'h0);

    // timeout after 999 idle cycles
    send(8'hE0);
    repeat (998) tick();
    chk("to_early_err", 16'(bus.err), 16'h0);
    tick();
    chk("to_err",   16'(bus.err), 16'h1);
    chk("to_valid", 16'(bus.code_valid), 16'h0);
    tick();
    chk("to_err_end", 16'(bus.err), 16'h0);
    send(8'h6B);
    chk_code("to_after", 16'h006B, 1'b0, 4'b0000);

    // byte arriving in the would-be timeout cycle wins
    send(8'hE0);
    repeat (998) tick();
    send(8'h74);
    chk("win_err", 16'(bus.err), 16'h0);
    chk_code("win", 16'hE074, 1'b0, 4'b0010);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk_code("win_clr", 16'hE074, 1'b1, 4'b0000);

    // typematic repeat of left
    send(8'hE0); send(8'h6B);
    chk_code("left_1", 16'hE06B, 1'b0, 4'b1000);
    send(8'hE0); send(8'h6B);
`ifdef PS2_REPEAT_FILTER_EN
    chk("left_rep_valid", 16'(bus.code_valid), 16'h0);
`else
    chk("left_rep_valid", 16'(bus.code_valid), 16'h1);
`endif
    chk("left_rep_arrows", 16'(arrows()), 16'h8);

    // down held alongside left
    send(8'hE0); send(8'h72);
    chk_code("down_make", 16'hE072, 1'b0, 4'b1100);

    // asynchronous reset mid-sequence
    send(8'hE0); send(8'hF0);
    areset = 1'b1;
    #1;
    chk("arst_valid",  16'(bus.code_valid), 16'h0);
    chk("arst_code",   bus.scancode, 16'h0000);
    chk("arst_arrows", 16'(arrows()), 16'h0);
    tick();
    areset = 1'b0;
    tick();
    send(8'h74);
    chk_code("arst_after", 16'h0074, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
